// File: rtl/ut_defs.sv
// Shared definitions for the 8-bit accumulator processor: state encodings,
// ISA opcodes and datapath widths.
package ut_defs;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 6;

  typedef enum logic [2:0] {
    INIT   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    ALU    = 3'd4
  } state_t;

  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

endpackage

// File: rtl/ut_control_unit.sv
// Control-unit FSM for the accumulator processor: sequences PC, IR, ACC,
// carry flag, ALU select and RAM strobes. Contains no datapath.
module ut_control_unit
  import ut_defs::*;
#(
  parameter int OP_W = 2,
  parameter int ST_W = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic [OP_W-1:0] opcode,
  input  logic            carry,
  output logic            clear_PC,
  output logic            load_PC,
  output logic            enable_PC,
  output logic            load_RI,
  output logic            load_RA,
  output logic            load_RC,
  output logic            init_C,
  output logic            sel_UAL,
  output logic            sel_ADR,
  output logic            en_mem,
  output logic            we_mem,
  output logic [ST_W-1:0] state_dbg
);

  state_t state;
  state_t state_next;

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= INIT;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // NOTE: every output and the next state get a default before the case,
  // so no path through the decoder can infer a latch.
  always_comb begin
    state_next = INIT;
    clear_PC   = 1'b0;
    load_PC    = 1'b0;
    enable_PC  = 1'b0;
    load_RI    = 1'b0;
    load_RA    = 1'b0;
    load_RC    = 1'b0;
    init_C     = 1'b0;
    sel_UAL    = 1'b0;
    sel_ADR    = 1'b0;
    en_mem     = 1'b0;
    we_mem     = 1'b0;

    unique case (state)
      INIT: begin
        clear_PC   = 1'b1;
        enable_PC  = 1'b1;
        init_C     = 1'b1;
        state_next = FETCH;
      end
      FETCH: begin
        en_mem     = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        load_RI    = 1'b1;
        enable_PC  = 1'b1;
        state_next = EXEC;
      end
      EXEC: begin
        sel_ADR = 1'b1;
        unique case (opcode)
          OP_NOR, OP_ADD: begin
            en_mem     = 1'b1;
            state_next = ALU;
          end
          OP_STA: begin
            en_mem     = 1'b1;
            we_mem     = 1'b1;
            state_next = FETCH;
          end
          default: begin
            // JCC: jump when no carry; the flag is consumed either way.
            load_PC    = ~carry;
            init_C     = 1'b1;
            state_next = FETCH;
          end
        endcase
      end
      ALU: begin
        load_RA    = 1'b1;
        sel_UAL    = opcode[0];
        load_RC    = (opcode == OP_ADD);
        state_next = FETCH;
      end
      default: state_next = INIT;
    endcase

    // Reset or a frozen clock enable silences every strobe, dropping any
    // in-flight RAM write.
    if (!(rst && ce)) begin
      clear_PC  = 1'b0;
      load_PC   = 1'b0;
      enable_PC = 1'b0;
      load_RI   = 1'b0;
      load_RA   = 1'b0;
      load_RC   = 1'b0;
      init_C    = 1'b0;
      sel_UAL   = 1'b0;
      sel_ADR   = 1'b0;
      en_mem    = 1'b0;
      we_mem    = 1'b0;
    end
  end

  assign state_dbg = ST_W'(state);

endmodule

// File: tb/tb_ut_control_unit.sv
// Self-checking bench for ut_control_unit: per-cycle strobe vectors are
// compared against an instruction-level plan of each ISA instruction.
module tb_ut_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ce = 1'b1;
  logic [1:0] opcode = 2'b00;
  logic       carry = 1'b0;
  logic clear_PC, load_PC, enable_PC, load_RI, load_RA, load_RC, init_C;
  logic sel_UAL, sel_ADR, en_mem, we_mem;
  logic [2:0] state_dbg;

  int tests = 0;
  int fails = 0;

  // Instruction-level model: m_step = -1 for the reset cycle, else the
  // cycle index within the current instruction; m_op is that instruction.
  int m_step = -1;
  int m_op = 0;
  int m_writes = 0;
  int ram_writes = 0;

  wire [13:0] obs = {state_dbg, clear_PC, load_PC, enable_PC, load_RI, load_RA,
                     load_RC, init_C, sel_UAL, sel_ADR, en_mem, we_mem};

  ut_control_unit dut (
    .clk(clk), .rst(rst), .ce(ce), .opcode(opcode), .carry(carry),
    .clear_PC(clear_PC), .load_PC(load_PC), .enable_PC(enable_PC),
    .load_RI(load_RI), .load_RA(load_RA), .load_RC(load_RC),
    .init_C(init_C), .sel_UAL(sel_UAL), .sel_ADR(sel_ADR),
    .en_mem(en_mem), .we_mem(we_mem), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // A RAM write happens on any edge that sees an enabled write strobe.
  always @(posedge clk) if (en_mem && we_mem) ram_writes++;

  function automatic int cost(input int op);
    return (op < 2) ? 4 : 3;
  endfunction

  // Expected strobes for cycle `step` of instruction `op`, in obs order.
  function automatic logic [13:0] plan(input int step, input int op, input bit c);
    logic cl, lp, en, ri, ra, rc, ic, su, sa, em, we;
    logic [2:0] st;
    {cl, lp, en, ri, ra, rc, ic, su, sa, em, we} = '0;
    st = (step < 0) ? 3'd0 : 3'(step + 1);
    if (step < 0) begin
      cl = 1; en = 1; ic = 1;
    end else if (step == 0) begin
      em = 1;
    end else if (step == 1) begin
      ri = 1; en = 1;
    end else if (step == 2) begin
      sa = 1;
      if (op == 3) begin
        lp = !c; ic = 1;
      end else begin
        em = 1; we = (op == 2);
      end
    end else begin
      ra = 1; su = op[0]; rc = (op == 1);
    end
    return {st, cl, lp, en, ri, ra, rc, ic, su, sa, em, we};
  endfunction

  // One clock of normal operation; opcode is only meaningful from EXEC on,
  // so earlier cycles get random garbage on the opcode input.
  task automatic cycle(input bit ce_v, input bit carry_v, output logic [13:0] exp);
    @(negedge clk);
    rst = 1'b1;
    ce = ce_v;
    carry = carry_v;
    opcode = (m_step >= 2) ? 2'(m_op) : 2'($urandom_range(0, 3));
    #1;
    if (!ce_v) begin
      exp = {((m_step < 0) ? 3'd0 : 3'(m_step + 1)), 11'b0};
    end else begin
      exp = plan(m_step, m_op, carry_v);
      if (m_step == 2 && m_op == 2) m_writes++;
      if (m_step < 0 || m_step + 1 >= cost(m_op)) m_step = 0;
      else m_step++;
    end
  endtask

  task automatic test_reset();
    logic [13:0] exp;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rst = 1'b0; ce = 1'b1; opcode = 2'($urandom_range(0, 3)); carry = 1'b1;
      #1;
      tests++;
      if (obs !== 14'h0) begin
        fails++;
        $display("FAIL reset_hold[%0d]: got %h expected %h", i, obs, 14'h0);
      end
    end
    m_step = -1;
    m_op = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b0, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL reset_seq[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_instr(input string name, input int op, input bit c);
    logic [13:0] exp;
    m_op = op;
    for (int i = 0; i < cost(op); i++) begin
      cycle(1'b1, c, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL %s[%0d]: got %h expected %h", name, i, obs, exp);
      end
    end
    tests++;
    if (m_step !== 0) begin
      fails++;
      $display("FAIL %s_len: model step %0d expected 0", name, m_step);
    end
  endtask

  task automatic test_ce_stall();
    logic [13:0] exp;
    m_op = 0;
    cycle(1'b1, 1'b0, exp);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 1)), exp);
      tests++;
      if (obs !== {3'd2, 11'b0}) begin
        fails++;
        $display("FAIL ce_stall[%0d]: got %h expected %h", i, obs, {3'd2, 11'b0});
      end
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL ce_resume[%0d]: got %h expected %h", i, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [13:0] exp;
    for (int n = 0; n < 300; n++) begin
      if (m_step == 0) m_op = $urandom_range(0, 3);
      cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL random[%0d]: got %h expected %h op %0d", n, obs, exp, m_op);
      end
    end
    while (m_step != 0) cycle(1'b1, 1'b0, exp);
  endtask

  task automatic test_midop_reset();
    logic [13:0] exp;
    int writes_before;
    m_op = 2;
    cycle(1'b1, 1'b0, exp);
    cycle(1'b1, 1'b0, exp);
    writes_before = ram_writes;
    @(negedge clk);
    rst = 1'b0; ce = 1'b1; opcode = 2'b10;
    #1;
    tests++;
    if (obs !== {3'd3, 11'b0}) begin
      fails++;
      $display("FAIL midop_exec: got %h expected %h", obs, {3'd3, 11'b0});
    end
    @(negedge clk);
    ce = 1'b0;
    #1;
    tests++;
    if (obs !== 14'h0) begin
      fails++;
      $display("FAIL midop_init: got %h expected %h", obs, 14'h0);
    end
    tests++;
    if (ram_writes !== writes_before) begin
      fails++;
      $display("FAIL midop_write: got %0d writes expected %0d", ram_writes, writes_before);
    end
    m_step = -1;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, exp);
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL midop_restart[%0d]: got %h expected %h", i, obs, exp);
      end
    end
    tests++;
    if (ram_writes !== m_writes) begin
      fails++;
      $display("FAIL ram_writes: got %0d expected %0d", ram_writes, m_writes);
    end
  endtask

  initial begin
    test_reset();
    test_instr("add", 1, 1'b0);
    test_instr("nor", 0, 1'b1);
    test_instr("sta", 2, 1'b1);
    test_instr("jcc_c0", 3, 1'b0);
    test_instr("jcc_c1", 3, 1'b1);
    test_ce_stall();
    test_random();
    test_midop_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ut_control_unit.md
Name: ut_control_unit

Overview:
Control-unit FSM for the 8-bit accumulator processor. It sequences the program counter (clear/load/increment), instruction-register and accumulator loads, ALU function select, carry-flag handling, address mux and memory strobes. It executes the 4-instruction ISA: opcode[1:0] is the top two bits of the instruction; the 6-bit operand address feeds the PC load input and the address mux. It sits beside the PC, IR, accumulator, carry register and synchronous RAM; it contains no datapath.

Parameters:
OP_W, 2, opcode width (fixed ISA: 00 NOR, 01 ADD, 10 STA, 11 JCC)
ST_W, 3, state register width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-low reset
ce  in  1  clock enable; 0 freezes the FSM
opcode  in  OP_W  IR[7:6], valid from the cycle after load_RI
carry  in  1  registered carry flag
clear_PC  out  1  to PC; forces 0 when enable_PC=1
load_PC  out  1  to PC; loads IR operand address
enable_PC  out  1  to PC; increment, or clear with clear_PC
load_RI  out  1  capture RAM read data into IR
load_RA  out  1  capture ALU result into accumulator
load_RC  out  1  capture ALU carry into carry register
init_C  out  1  synchronous clear of carry register
sel_UAL  out  1  0=NOR, 1=ADD
sel_ADR  out  1  RAM address mux: 0=PC, 1=IR operand
en_mem  out  1  RAM access enable (read latency 1 cycle)
we_mem  out  1  RAM write (accumulator to mem[IR addr])
state_dbg  out  ST_W  current state encoding, debug only

Behaviour:
- State register updates only on the rising clk edge when rst=1 and ce=1. rst=0 at an edge forces INIT regardless of ce.
- While rst=0 or ce=0, all strobes are 0: clear_PC, load_PC, enable_PC, load_RI, load_RA, load_RC, init_C, en_mem and we_mem. sel_UAL=0, sel_ADR=0. state_dbg still shows the state.
- Strobes are combinational decode of state, opcode and carry (Moore, plus opcode/carry dependence in EXEC).
- INIT: clear_PC=1, enable_PC=1, init_C=1, next FETCH. The PC reaches 0 without relying on its own reset.
- FETCH: sel_ADR=0, en_mem=1, next DECODE.
- DECODE: load_RI=1 and enable_PC=1 (PC+1), next EXEC.
- EXEC: sel_ADR=1.
  - opcode 00/01: en_mem=1, next ALU.
  - opcode 10 (STA): en_mem=1, we_mem=1, next FETCH.
  - opcode 11 (JCC): load_PC=1 only when carry=0; init_C=1 always; next FETCH.
- ALU: load_RA=1, sel_UAL=opcode[0], load_RC=1 only for ADD (01), next FETCH.
- Never assert load_PC together with enable_PC. Never assert we_mem outside EXEC.
- Instruction cost: NOR/ADD 4 cycles; STA and JCC 3 cycles.
- PC wrap 63->0 is handled by the PC. The controller does not detect it.
- Undefined state encodings go to INIT on the next enabled edge.
- Reset mid-instruction: an in-flight write is dropped (we_mem is forced 0 during rst=0). The first post-reset cycle is INIT.
- ce=0 mid-instruction: state held, strobes 0. Execution resumes identically when ce returns to 1. IR and accumulator are not disturbed.

Decomposition:
- Shared include/package ut_defs holds:
  - state localparams: INIT=0, FETCH=1, DECODE=2, EXEC=3, ALU=4
  - opcode localparams: OP_NOR, OP_ADD, OP_STA, OP_JCC
  - widths: DATA_W=8, ADDR_W=6
- Single module: state register plus one combinational output decoder. No sub-module is warranted.

Test Plan:
- Reset: rst=0 for 2 cycles, then 1 with ce=1 -> state_dbg INIT, then FETCH, DECODE, EXEC. The INIT cycle shows clear_PC=enable_PC=init_C=1.
- ADD: opcode=01 -> EXEC en_mem=1, sel_ADR=1, then ALU with load_RA=1, load_RC=1, sel_UAL=1; next state FETCH; 4 cycles total.
- STA: opcode=10 -> in EXEC, en_mem=1, we_mem=1, sel_ADR=1 for exactly 1 cycle; load_RA=0; back to FETCH after 3 cycles.
- JCC: opcode=11 with carry=0 -> load_PC=1, init_C=1. With carry=1 -> load_PC=0, init_C=1. enable_PC=0 in both cases.
- ce stall: drop ce for 3 cycles while in DECODE -> state_dbg stays DECODE and all strobes are 0. On the ce=1 edge, load_RI=enable_PC=1 once.
- Mid-op reset: assert rst=0 while in EXEC with opcode=10 -> we_mem=0 immediately, next state INIT. Bench model shows no RAM write.
